// File: rtl/fixed_activation_unroller.sv
// fixed_activation_unroller
// Gathers consecutive NARROW_NUM-element beats from an activation stage back
// into one WIDE_NUM-element vector. The first beat of a vector fills the
// lowest indices. Element bits pass through untouched. Full throughput: a new
// beat is accepted in the same cycle that a completed vector is consumed.
module fixed_activation_unroller #(
    parameter int DATA_WIDTH = 8,
    parameter int NARROW_NUM = 1,
    parameter int WIDE_NUM   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [NARROW_NUM],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [WIDE_NUM],
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int BEATS = WIDE_NUM / NARROW_NUM;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // A wide vector must be an exact number of narrow beats.
    if (NARROW_NUM < 1 || (WIDE_NUM % NARROW_NUM) != 0) begin : g_bad_params
        $error("WIDE_NUM must be a positive integer multiple of NARROW_NUM");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q [WIDE_NUM];
    logic [DATA_WIDTH-1:0]   data_d [WIDE_NUM];
    logic                    in_fire;
    logic                    out_fire;

    assign in_fire  = data_in_valid & data_in_ready;
    assign out_fire = data_out_valid & data_out_ready;

    // Each output slot belongs to one fixed beat position and lane. It loads
    // when a beat is accepted at that position. In FULL the counter sits at
    // zero, so a beat taken alongside out_fire lands in the lowest slots.
    for (genvar k = 0; k < WIDE_NUM; k++) begin : g_slot
        assign data_d[k] = (in_fire && (cnt_q == CNT_W'(k / NARROW_NUM)))
                           ? data_in[k % NARROW_NUM] : data_q[k];
    end

    assign data_out = data_q;

    // State, beat counter and vector register; reset discards any partial vector
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            data_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Next-state and beat-counter decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            COLLECT: begin
                if (in_fire) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (out_fire) begin
                    if (in_fire) begin
                        if (BEATS == 1) begin
                            // A single beat completes the next vector immediately.
                            state_d = FULL;
                            cnt_d   = '0;
                        end else begin
                            state_d = COLLECT;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake outputs. In FULL, input readiness follows data_out_ready
    // combinationally, so a beat can enter in the same cycle the vector leaves.
    always_comb begin
        data_out_valid = (state_q == FULL);
        data_in_ready  = (state_q == COLLECT) ? 1'b1 : data_out_ready;
    end

endmodule

// File: tb/tb_fixed_activation_unroller.sv
// Bench for fixed_activation_unroller. It covers the default 1->4 configuration
// with a scoreboard, plus 2->4 and the degenerate 2->2 configuration.
module tb_fixed_activation_unroller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: NARROW_NUM=1, WIDE_NUM=4
    logic [7:0] a_in  [1];
    logic [7:0] a_out [4];
    logic       a_iv, a_ir, a_ov, a_or;

    // Instance B: NARROW_NUM=2, WIDE_NUM=4
    logic [7:0] b_in  [2];
    logic [7:0] b_out [4];
    logic       b_iv, b_ir, b_ov, b_or;

    // Instance C: NARROW_NUM=2, WIDE_NUM=2 (single-entry slice)
    logic [7:0] c_in  [2];
    logic [7:0] c_out [2];
    logic       c_iv, c_ir, c_ov, c_or;

    fixed_activation_unroller #(.DATA_WIDTH(8), .NARROW_NUM(1), .WIDE_NUM(4)) u_a (
        .clk(clk), .rst(rst),
        .data_in(a_in), .data_in_valid(a_iv), .data_in_ready(a_ir),
        .data_out(a_out), .data_out_valid(a_ov), .data_out_ready(a_or)
    );

    fixed_activation_unroller #(.DATA_WIDTH(8), .NARROW_NUM(2), .WIDE_NUM(4)) u_b (
        .clk(clk), .rst(rst),
        .data_in(b_in), .data_in_valid(b_iv), .data_in_ready(b_ir),
        .data_out(b_out), .data_out_valid(b_ov), .data_out_ready(b_or)
    );

    fixed_activation_unroller #(.DATA_WIDTH(8), .NARROW_NUM(2), .WIDE_NUM(2)) u_c (
        .clk(clk), .rst(rst),
        .data_in(c_in), .data_in_valid(c_iv), .data_in_ready(c_ir),
        .data_out(c_out), .data_out_valid(c_ov), .data_out_ready(c_or)
    );

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] sbq [$];
    int          m_cnt = 0;
    logic [31:0] m_vec = '0;

    function automatic logic [31:0] pack_a();
        return {a_out[3], a_out[2], a_out[1], a_out[0]};
    endfunction

    // One cycle on instance A: drive at the falling edge, settle, score, advance.
    task automatic cycle_a(input logic v, input logic [7:0] d, input logic r);
        logic [31:0] exp;
        a_iv = v; a_in[0] = d; a_or = r;
        #1;
        if (a_ov && a_or) begin
            nvec++;
            if (sbq.size() == 0) begin
                nerr++;
                $display("FAIL a_extra_vector got=%h expected=none", pack_a());
            end else begin
                exp = sbq.pop_front();
                if (pack_a() !== exp) begin
                    nerr++;
                    $display("FAIL a_vector got=%h expected=%h", pack_a(), exp);
                end
            end
        end
        if (a_iv && a_ir && !rst) begin
            m_vec[m_cnt*8 +: 8] = d;
            if (m_cnt == 3) begin
                sbq.push_back(m_vec);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        sbq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        nvec++;
        if (a_ov !== 1'b0 || pack_a() !== 32'h0) begin
            nerr++;
            $display("FAIL reset_a valid=%b data=%h expected valid=0 data=0", a_ov, pack_a());
        end
        nvec++;
        if (a_ir !== 1'b1) begin
            nerr++;
            $display("FAIL reset_a_ready got=%b expected=1", a_ir);
        end
        nvec++;
        if (c_ov !== 1'b0 || c_out[0] !== 8'h0 || c_out[1] !== 8'h0) begin
            nerr++;
            $display("FAIL reset_c valid=%b data=%h%h expected 0", c_ov, c_out[1], c_out[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        cycle_a(1'b1, 8'h11, 1'b1);
        cycle_a(1'b1, 8'h22, 1'b1);
        cycle_a(1'b1, 8'h33, 1'b1);
        nvec++;
        if (a_ov !== 1'b0) begin
            nerr++;
            $display("FAIL basic_early_valid got=%b expected=0", a_ov);
        end
        cycle_a(1'b1, 8'h44, 1'b1);
        nvec++;
        if (a_ov !== 1'b1 || pack_a() !== 32'h44332211) begin
            nerr++;
            $display("FAIL basic_latency valid=%b data=%h expected valid=1 data=44332211", a_ov, pack_a());
        end
        cycle_a(1'b0, 8'h00, 1'b1);
        nvec++;
        if (a_ov !== 1'b0) begin
            nerr++;
            $display("FAIL basic_valid_drop got=%b expected=0", a_ov);
        end
    endtask

    task automatic test_backpressure();
        cycle_a(1'b1, 8'h61, 1'b1);
        cycle_a(1'b1, 8'h62, 1'b1);
        cycle_a(1'b1, 8'h63, 1'b1);
        cycle_a(1'b1, 8'h64, 1'b1);
        for (int i = 0; i < 5; i++) begin
            a_iv = 1'b1; a_in[0] = 8'h55; a_or = 1'b0;
            #1;
            nvec++;
            if (a_ir !== 1'b0) begin
                nerr++;
                $display("FAIL bp_ready cycle=%0d got=%b expected=0", i, a_ir);
            end
            cycle_a(1'b1, 8'h55, 1'b0);
            nvec++;
            if (a_ov !== 1'b1 || pack_a() !== 32'h64636261) begin
                nerr++;
                $display("FAIL bp_hold cycle=%0d valid=%b data=%h expected valid=1 data=64636261", i, a_ov, pack_a());
            end
        end
        cycle_a(1'b1, 8'h55, 1'b1);
        nvec++;
        if (a_ov !== 1'b0 || a_out[0] !== 8'h55) begin
            nerr++;
            $display("FAIL bp_release valid=%b slot0=%h expected valid=0 slot0=55", a_ov, a_out[0]);
        end
        cycle_a(1'b1, 8'h56, 1'b1);
        cycle_a(1'b1, 8'h57, 1'b1);
        cycle_a(1'b1, 8'h58, 1'b1);
        cycle_a(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_stream();
        int seen;
        int last;
        seen = 0;
        last = 0;
        for (int i = 0; i < 64; i++) begin
            cycle_a(1'b1, 8'($urandom_range(0, 255)), 1'b1);
            if (a_ov) begin
                if (seen > 0) begin
                    nvec++;
                    if (i - last != 4) begin
                        nerr++;
                        $display("FAIL stream_period got=%0d expected=4", i - last);
                    end
                end
                seen++;
                last = i;
            end
        end
        cycle_a(1'b0, 8'h00, 1'b1);
        nvec++;
        if (seen != 16 || sbq.size() != 0) begin
            nerr++;
            $display("FAIL stream_count got=%0d left=%0d expected=16 left=0", seen, sbq.size());
        end
    endtask

    task automatic test_bubbles_reset();
        cycle_a(1'b1, 8'h01, 1'b1);
        cycle_a(1'b1, 8'h02, 1'b1);
        for (int i = 0; i < 3; i++) cycle_a(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        a_iv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        sbq.delete();
        cycle_a(1'b1, 8'hA0, 1'b1);
        cycle_a(1'b0, 8'h00, 1'b1);
        cycle_a(1'b1, 8'hA1, 1'b1);
        cycle_a(1'b1, 8'hA2, 1'b1);
        cycle_a(1'b1, 8'hA3, 1'b1);
        nvec++;
        if (a_ov !== 1'b1 || pack_a() !== 32'hA3A2A1A0) begin
            nerr++;
            $display("FAIL midreset_vector valid=%b data=%h expected valid=1 data=a3a2a1a0", a_ov, pack_a());
        end
        cycle_a(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_wide_beat();
        b_or = 1'b1;
        b_iv = 1'b1; b_in = '{8'h01, 8'h02};
        @(negedge clk);
        nvec++;
        if (b_ov !== 1'b0) begin
            nerr++;
            $display("FAIL wide_early_valid got=%b expected=0", b_ov);
        end
        b_in = '{8'h03, 8'h04};
        @(negedge clk);
        b_iv = 1'b0;
        nvec++;
        if (b_ov !== 1'b1 || {b_out[3], b_out[2], b_out[1], b_out[0]} !== 32'h04030201) begin
            nerr++;
            $display("FAIL wide_vector valid=%b data=%h%h%h%h expected valid=1 data=04030201",
                     b_ov, b_out[3], b_out[2], b_out[1], b_out[0]);
        end
        @(negedge clk);
        nvec++;
        if (b_ov !== 1'b0) begin
            nerr++;
            $display("FAIL wide_valid_drop got=%b expected=0", b_ov);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e0, e1;
        c_or = 1'b1;
        c_iv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e0 = 8'($urandom_range(0, 255));
            e1 = 8'($urandom_range(0, 255));
            c_in = '{e0, e1};
            @(negedge clk);
            nvec++;
            if (c_ov !== 1'b1 || c_out[0] !== e0 || c_out[1] !== e1) begin
                nerr++;
                $display("FAIL degen_stream beat=%0d valid=%b data=%h,%h expected valid=1 data=%h,%h",
                         i, c_ov, c_out[0], c_out[1], e0, e1);
            end
        end
        c_or = 1'b0;
        c_in = '{8'hEE, 8'hFF};
        #1;
        nvec++;
        if (c_ir !== 1'b0) begin
            nerr++;
            $display("FAIL degen_ready got=%b expected=0", c_ir);
        end
        @(negedge clk);
        nvec++;
        if (c_ov !== 1'b1 || c_out[0] !== e0 || c_out[1] !== e1) begin
            nerr++;
            $display("FAIL degen_hold data=%h,%h expected=%h,%h", c_out[0], c_out[1], e0, e1);
        end
        c_iv = 1'b0;
        c_or = 1'b1;
        @(negedge clk);
        nvec++;
        if (c_ov !== 1'b0) begin
            nerr++;
            $display("FAIL degen_drain got=%b expected=0", c_ov);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_iv = 1'b0; a_in[0] = 8'h00; a_or = 1'b0;
        b_iv = 1'b0; b_in = '{8'h00, 8'h00}; b_or = 1'b0;
        c_iv = 1'b0; c_in = '{8'h00, 8'h00}; c_or = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_stream();
        test_bubbles_reset();
        test_wide_beat();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fixed_activation_unroller.md
Name: fixed_activation_unroller

Overview:
- Downstream neighbour of the fixed-point activation stages (logsigmoid, etc.).
- Those stages emit a narrow vector of OUT_NUM-parallel elements per beat, after their roller narrows the input.
- This block gathers consecutive narrow beats back into a wide vector of WIDE_NUM elements, so the next layer sees the original parallelism.
- Streaming valid/ready on both sides, full throughput: one narrow beat accepted per cycle, including the cycle in which a completed wide vector is consumed.

Parameters:
- DATA_WIDTH, 8: bits per element.
- NARROW_NUM, 1: elements per input beat. Equals the activation stage's output parallelism.
- WIDE_NUM, 4: elements per output vector. Must be an integer multiple of NARROW_NUM; elaboration fails otherwise.
- BEATS, WIDE_NUM/NARROW_NUM: derived local parameter, not overridable. Number of input beats per output vector.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- data_in, input, DATA_WIDTH x [NARROW_NUM]: unpacked array of narrow beat elements.
- data_in_valid, input, 1: narrow beat valid.
- data_in_ready, output, 1: block can accept a narrow beat.
- data_out, output, DATA_WIDTH x [WIDE_NUM]: unpacked array, registered wide vector.
- data_out_valid, output, 1: wide vector complete.
- data_out_ready, input, 1: downstream accepts the wide vector.

Behaviour:
- Reset (rst high at a clock edge):
  - data_out_valid = 0.
  - beat counter cnt = 0.
  - all data_out elements = 0.
  - FSM enters COLLECT.
  - Reset wins over every simultaneous event; any partial vector is discarded.
- Handshakes:
  - in_fire = data_in_valid & data_in_ready.
  - out_fire = data_out_valid & data_out_ready.
- FSM state COLLECT (data_out_valid = 0, data_in_ready = 1):
  - On in_fire, data_in[j] is written to data_out[cnt*NARROW_NUM + j] for j = 0..NARROW_NUM-1.
  - If cnt == BEATS-1: cnt <= 0 and go to FULL. Otherwise cnt <= cnt+1.
- FSM state FULL (data_out_valid = 1):
  - data_in_ready = data_out_ready. This is a combinational path from data_out_ready; it is documented and accepted.
  - On out_fire without in_fire: go to COLLECT, cnt stays 0.
  - On out_fire with in_fire: the beat is written into slots 0..NARROW_NUM-1. Then:
    - if BEATS == 1, stay in FULL (valid stays high, back-to-back vectors);
    - otherwise cnt <= 1 and go to COLLECT.
  - While data_out_valid is high and data_out_ready is low, data_out and data_out_valid hold stable.
- Ordering: the first beat of a vector fills the lowest indices and the last beat fills the highest. This matches the roller's low-index-first emission.
- Latency: data_out_valid rises in the cycle after the final beat's in_fire.
- Throughput: sustained 1 beat/cycle when data_out_ready is held high. Peak output rate is 1 wide vector per BEATS cycles.
- Slots not yet written in the current vector hold their previous contents. They are only defined while data_out_valid = 1.
- Counter width: $clog2(BEATS), minimum 1 bit. cnt never exceeds BEATS-1.
- No arithmetic is performed on element values; bits pass unmodified.
- BEATS == 1 degenerates to a single-entry register slice with the same handshake rules.
- Gaps in data_in_valid mid-vector are allowed; cnt holds until the next in_fire.

Test Plan:
- Basic, reset → 4 beats → 1 vector:
  - Setup: NARROW_NUM=1, WIDE_NUM=4; after reset drive 0x11, 0x22, 0x33, 0x44 with data_out_ready=1.
  - Expect: data_out_valid high exactly one cycle after the 0x44 beat, with data_out[0..3] = 11, 22, 33, 44.
  - Expect: data_out_valid = 0 and data_out = 0 immediately after reset.
- Backpressure:
  - Setup: complete a vector, hold data_out_ready=0 for 5 cycles, keep data_in_valid=1 with 0x55.
  - Expect: data_in_ready = 0, data_out unchanged and valid high for all 5 cycles.
  - Then raise ready: out_fire occurs and 0x55 lands in data_out[0] in the same cycle.
- Continuous streaming:
  - Setup: 64 random beats, data_out_ready=1 throughout, valid always high.
  - Expect: 16 vectors in order with no dropped or duplicated element; each vector produced every 4 cycles after the first.
- Bubbles and mid-vector reset:
  - Setup: send 2 beats, idle 3 cycles, assert rst for 1 cycle, then send 0xA0..0xA3.
  - Expect: the first 2 beats are discarded; output vector = A0, A1, A2, A3.
- Wide beat and degenerate case:
  - Setup 1: NARROW_NUM=2, WIDE_NUM=4; beats {0x01,0x02} then {0x03,0x04}.
  - Expect: data_out = 01, 02, 03, 04.
  - Setup 2: NARROW_NUM=WIDE_NUM=2 with data_out_ready=1 and valid every cycle.
  - Expect: data_out_valid stays high continuously and data_out updates every cycle.
